// File: rtl/bounded_count_sched_if.sv
// Handshake bundle between the requesting agents and the shared counter scheduler.
// Requesters drive req/limit_in/step; the scheduler drives grant and the counter view.
interface bounded_count_sched_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 31
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] limit_in;
    logic                  step;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic [WIDTH-1:0]      active_limit;
    logic                  done;
    logic                  abort;

    modport master (
        output req, limit_in, step,
        input  grant, busy, count, active_limit, done, abort
    );

    modport slave (
        input  req, limit_in, step,
        output grant, busy, count, active_limit, done, abort
    );
endinterface

// File: rtl/bounded_count_sched.sv
// Round-robin owner selection in front of one bounded up-counter.
// The owner's limit is clamped to CEIL; done on completion, abort on req drop.
module bounded_count_sched #(
    parameter int WIDTH = 31,
    parameter int NREQ  = 2,
    parameter int CEIL  = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    bounded_count_sched_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WIDTH-1:0] CEIL_W = WIDTH'(CEIL);
    localparam logic [PW-1:0]    LAST   = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;

    logic             any_req;
    logic [PW-1:0]    win;
    logic [PW:0]      idx;
    logic [WIDTH-1:0] win_lim;
    logic [WIDTH-1:0] win_lim_c;
    logic [WIDTH:0]   count_inc;
    logic [PW-1:0]    owner_nxt;

    // First pending requester at or after rr_ptr, wrapping past NREQ-1.
    always_comb begin
        any_req = 1'b0;
        win     = rr_ptr_q;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!any_req && bus.req[idx[PW-1:0]]) begin
                any_req = 1'b1;
                win     = idx[PW-1:0];
            end
        end
    end

    assign win_lim   = bus.limit_in[win*WIDTH +: WIDTH];
    assign win_lim_c = (win_lim > CEIL_W) ? CEIL_W : win_lim;
    assign count_inc = {1'b0, count_q} + (WIDTH+1)'(1);
    assign owner_nxt = (owner_q == LAST) ? '0 : owner_q + PW'(1);

    // Next-state and next-output computation for the scheduler FSM.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        count_d  = count_q;
        limit_d  = limit_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = win;
                    limit_d = win_lim_c;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = '0;
                grant_d = NREQ'(1) << owner_q;
                if (limit_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.req[owner_q]) begin
                    state_d  = IDLE;
                    abort_d  = 1'b1;
                    grant_d  = '0;
                    rr_ptr_d = owner_nxt;
                end else if (count_q == limit_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (bus.step) begin
                    // Carry can never set while limit <= CEIL; hold instead of wrapping.
                    count_d = count_inc[WIDTH] ? count_q : count_inc[WIDTH-1:0];
                end
            end
            DONE: begin
                grant_d  = '0;
                rr_ptr_d = owner_nxt;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            count_q  <= '0;
            limit_q  <= '0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.count        = count_q;
    assign bus.active_limit = limit_q;
    assign bus.done         = done_q;
    assign bus.abort        = abort_q;

    // During LOAD the previous owner's count is still held against the new limit.
    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        (state_q == LOAD) || (count_q <= limit_q));
    a_limit_ceil: assert property (@(posedge clk) disable iff (!rst)
        limit_q <= CEIL_W);
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(grant_q));
    a_done_abort: assert property (@(posedge clk) disable iff (!rst)
        !(done_q && abort_q));
    a_busy_grant: assert property (@(posedge clk) disable iff (!rst)
        (state_q == LOAD) || (bus.busy == (grant_q != '0)));
endmodule

// File: tb/tb_bounded_count_sched.sv
// Directed bench for bounded_count_sched with a procedural reference model.
// The model walks each ownership as a sequence of clock edges and is compared every cycle.
module tb_bounded_count_sched;
    localparam int WIDTH = 31;
    localparam int NREQ  = 2;
    localparam int CEIL  = 500;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    logic [NREQ-1:0] e_grant;
    bit              e_busy;
    bit              e_done;
    bit              e_abort;
    int              e_cnt;
    int              e_lim;
    int              m_ptr;

    bounded_count_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    bounded_count_sched #(
        .WIDTH(WIDTH),
        .NREQ (NREQ),
        .CEIL (CEIL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pick(input int ptr, input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic int clampv(input logic [WIDTH-1:0] v);
        return (v > CEIL) ? CEIL : int'(v);
    endfunction

    task automatic step_edge(output bit alive);
        @(posedge clk or negedge rst);
        alive = rst;
    endtask

    // Reference model: one pass of the loop body is one ownership.
    always begin : model
        int w;
        int lim;
        bit alive;
        bit aborted;
        e_grant = '0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_abort = 1'b0;
        e_cnt   = 0;
        e_lim   = 0;
        m_ptr   = 0;
        wait (rst === 1'b1);
        alive = 1'b1;
        while (alive) begin
            step_edge(alive);
            if (!alive) break;
            e_done  = 1'b0;
            e_abort = 1'b0;
            w = pick(m_ptr, bus.req);
            if (w < 0) continue;
            lim    = clampv(bus.limit_in[w*WIDTH +: WIDTH]);
            e_lim  = lim;
            e_busy = 1'b1;
            step_edge(alive);
            if (!alive) break;
            e_cnt   = 0;
            e_grant = NREQ'(1) << w;
            aborted = 1'b0;
            if (lim == 0) e_done = 1'b1;
            while (!e_done && !aborted) begin
                step_edge(alive);
                if (!alive) break;
                if (!bus.req[w]) begin
                    aborted = 1'b1;
                    e_abort = 1'b1;
                    e_grant = '0;
                    e_busy  = 1'b0;
                    m_ptr   = (w + 1) % NREQ;
                end else if (e_cnt == lim) begin
                    e_done = 1'b1;
                end else if (bus.step) begin
                    e_cnt++;
                end
            end
            if (!alive) break;
            if (aborted) continue;
            step_edge(alive);
            if (!alive) break;
            e_done  = 1'b0;
            e_grant = '0;
            e_busy  = 1'b0;
            m_ptr   = (w + 1) % NREQ;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("cmp_grant", bus.grant, e_grant);
            chk("cmp_busy", bus.busy, e_busy);
            chk("cmp_count", bus.count, e_cnt);
            chk("cmp_limit", bus.active_limit, e_lim);
            chk("cmp_done", bus.done, e_done);
            chk("cmp_abort", bus.abort, e_abort);
        end
    end

    task automatic set_lim(input int k, input int v);
        bus.limit_in[k*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < budget);
        chk("done_seen", bus.done, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, bus.grant, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_count"}, bus.count, 0);
        chk({tag, "_limit"}, bus.active_limit, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_abort"}, bus.abort, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        rst          = 1'b0;
        bus.req      = '0;
        bus.step     = 1'b0;
        bus.limit_in = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        cmp_en = 1'b1;

        // Single requester, limit 3.
        set_lim(0, 3);
        bus.req  = 2'b01;
        bus.step = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        chk("t1_load_grant", bus.grant, 0);
        chk("t1_load_busy", bus.busy, 1);
        @(negedge clk);
        chk("t1_grant", bus.grant, 2'b01);
        chk("t1_count0", bus.count, 0);
        wait_done(20, n);
        chk("t1_done_delay", n, 4);
        chk("t1_final_count", bus.count, 3);
        bus.req = '0;
        @(negedge clk);
        chk("t1_idle_grant", bus.grant, 0);
        chk("t1_idle_busy", bus.busy, 0);

        // Clamp: 700 requested, 500 used.
        set_lim(1, 700);
        bus.req = 2'b10;
        wait_done(600, n);
        chk("t2_done_delay", n, 503);
        chk("t2_limit", bus.active_limit, 500);
        chk("t2_count", bus.count, 500);
        bus.req = '0;
        @(negedge clk);

        // Round-robin with both requesting.
        set_lim(0, 2);
        set_lim(1, 2);
        bus.req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_done(20, n);
            chk("t3_owner", bus.grant, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i == 3) bus.req = '0;
        end
        @(negedge clk);

        // Step gating, then abort at count 4.
        set_lim(0, 10);
        bus.step = 1'b0;
        bus.req  = 2'b01;
        k = 0;
        while (!(bus.count == 4 && bus.grant == 2'b01) && k < 60) begin
            @(negedge clk);
            k++;
            if (!(bus.count == 4 && bus.grant == 2'b01)) bus.step = ~bus.step;
        end
        chk("t4_reached", bus.count, 4);
        bus.req = '0;
        @(negedge clk);
        chk("t4_abort", bus.abort, 1);
        chk("t4_hold", bus.count, 4);
        chk("t4_grant", bus.grant, 0);
        chk("t4_done", bus.done, 0);
        @(negedge clk);
        chk("t4_abort_pulse", bus.abort, 0);

        // Zero limit goes straight to DONE.
        set_lim(0, 0);
        bus.step = 1'b1;
        bus.req  = 2'b01;
        wait_done(10, n);
        chk("t5_done_delay", n, 2);
        chk("t5_count", bus.count, 0);
        chk("t5_grant", bus.grant, 2'b01);
        bus.req = '0;
        @(negedge clk);

        // Mid-run asynchronous reset, then fresh arbitration from pointer 0.
        set_lim(0, 10);
        bus.req = 2'b01;
        k = 0;
        while (!(bus.count == 5 && bus.grant != '0) && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("t6_reached", bus.count, 5);
        #2 rst = 1'b0;
        #1 chk_all_zero("t6_async");
        set_lim(0, 2);
        set_lim(1, 2);
        bus.req = 2'b11;
        @(negedge clk);
        rst = 1'b1;
        wait_done(20, n);
        chk("t6_done_delay", n, 5);
        chk("t6_first_owner", bus.grant, 2'b01);
        bus.req = 2'b10;
        wait_done(20, n);
        chk("t6_second_owner", bus.grant, 2'b10);
        bus.req = '0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
